// File: rtl/matmul_sched_pkg.sv
// Shared encodings for the GEMM tile-loop scheduler: command opcodes and FSM states.
package matmul_sched_pkg;

  localparam logic [1:0] OP_LOAD_A  = 2'd0;
  localparam logic [1:0] OP_LOAD_W  = 2'd1;
  localparam logic [1:0] OP_COMPUTE = 2'd2;
  localparam logic [1:0] OP_DRAIN   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_A = 3'd1,
    ST_ISSUE_W = 3'd2,
    ST_ISSUE_C = 3'd3,
    ST_ISSUE_D = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/matmul_tile_scheduler_if.sv
// Command port between the tile scheduler (master) and the matmul sequencer (slave).
interface matmul_tile_scheduler_if #(
  parameter int ARRAY_N    = 8,
  parameter int ARRAY_M    = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 10
);
  localparam int ROWS_W  = $clog2(ARRAY_N) + 1;
  localparam int COLS_W  = $clog2(ARRAY_M) + 1;
  localparam int DEPTH_W = $clog2(DEPTH) + 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ROWS_W-1:0]     cmd_rows;
  logic [COLS_W-1:0]     cmd_cols;
  logic [DEPTH_W-1:0]    cmd_depth;
  logic                  cmd_acc_clear;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_rows, cmd_cols, cmd_depth, cmd_acc_clear,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_rows, cmd_cols, cmd_depth, cmd_acc_clear,
    output cmd_ready
  );

endinterface

// File: rtl/tile_extent_calc.sv
// Valid extent of one tile along a dimension: min(TILE, total - offset), zero past the end.
module tile_extent_calc #(
  parameter int DW   = 7,
  parameter int TILE = 8,
  parameter int EW   = $clog2(TILE) + 1
) (
  input  logic [DW-1:0] i_total,
  input  logic [DW-1:0] i_offset,
  output logic [EW-1:0] o_extent
);
  localparam logic [DW-1:0] TILE_W = DW'(TILE);

  logic [DW-1:0] w_remain;

  // Remaining elements beyond the tile origin, clamped to one tile.
  always_comb begin
    w_remain = i_total - i_offset;
    if (i_offset >= i_total) begin
      o_extent = EW'(0);
    end else if (w_remain >= TILE_W) begin
      o_extent = EW'(TILE);
    end else begin
      o_extent = w_remain[EW-1:0];
    end
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// GEMM tile-loop scheduler: walks m-tiles, n-tiles and k-chunks and issues
// LOAD_A / LOAD_W / COMPUTE / DRAIN commands. Addresses are running sums (no multipliers);
// ARRAY_N and DEPTH are powers of two so the per-tile strides are shifts.
module matmul_tile_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int ARRAY_N    = 8,
  parameter int ARRAY_M    = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  dim_m,
  input  logic [DIM_WIDTH-1:0]  dim_k,
  input  logic [DIM_WIDTH-1:0]  dim_n,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] o_base,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  matmul_tile_scheduler_if.master cmd
);
  // Counters carry one extra bit so offset+tile never overflows.
  localparam int CW        = DIM_WIDTH + 1;
  localparam int ROWS_W    = $clog2(ARRAY_N) + 1;
  localparam int COLS_W    = $clog2(ARRAY_M) + 1;
  localparam int DEPTH_W   = $clog2(DEPTH) + 1;
  localparam int LOG_AN    = $clog2(ARRAY_N);
  localparam int LOG_DEPTH = $clog2(DEPTH);

  localparam logic [CW-1:0]         STEP_M   = CW'(ARRAY_N);
  localparam logic [CW-1:0]         STEP_N   = CW'(ARRAY_M);
  localparam logic [CW-1:0]         STEP_K   = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ASTEP_AM = ADDR_WIDTH'(ARRAY_M);
  localparam logic [ADDR_WIDTH-1:0] ASTEP_K  = ADDR_WIDTH'(DEPTH);

  state_t                r_state;
  logic [CW-1:0]         r_m, r_k, r_n;
  logic [CW-1:0]         r_m0, r_n0, r_k0;
  logic [ADDR_WIDTH-1:0] r_w_base;
  logic [ADDR_WIDTH-1:0] r_a_row;   // a_base + m0*K
  logic [ADDR_WIDTH-1:0] r_a_cur;   // a_base + m0*K + k0
  logic [ADDR_WIDTH-1:0] r_w_col;   // w_base + n0
  logic [ADDR_WIDTH-1:0] r_w_cur;   // w_base + k0*N + n0
  logic [ADDR_WIDTH-1:0] r_o_row;   // o_base + m0*N

  logic                  r_busy, r_done, r_err;
  logic                  r_cmd_valid;
  logic [1:0]            r_cmd_op;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [ROWS_W-1:0]     r_cmd_rows;
  logic [COLS_W-1:0]     r_cmd_cols;
  logic [DEPTH_W-1:0]    r_cmd_depth;
  logic                  r_cmd_acc_clear;

  logic                  w_fire;
  logic [CW-1:0]         w_m_tot, w_k_tot, w_n_tot;
  logic [CW-1:0]         w_m0_adv, w_n0_adv, w_k0_adv;
  logic                  w_last_m, w_last_n, w_last_k;
  logic [CW-1:0]         w_m0_nx, w_n0_nx, w_k0_nx;
  logic [ADDR_WIDTH-1:0] w_a_mstep, w_w_kstep, w_o_mstep;
  logic [ADDR_WIDTH-1:0] w_a_row_nx, w_a_cur_nx, w_w_col_nx;
  logic [ROWS_W-1:0]     w_rows_ext;
  logic [COLS_W-1:0]     w_cols_ext;
  logic [DEPTH_W-1:0]    w_depth_ext;

  // Loop bookkeeping: end-of-loop flags, strides, and counters of the command issued next.
  always_comb begin
    w_fire    = r_cmd_valid && cmd.cmd_ready;
    w_m_tot   = (r_state == ST_IDLE) ? CW'(dim_m) : r_m;
    w_k_tot   = (r_state == ST_IDLE) ? CW'(dim_k) : r_k;
    w_n_tot   = (r_state == ST_IDLE) ? CW'(dim_n) : r_n;
    w_m0_adv  = r_m0 + STEP_M;
    w_n0_adv  = r_n0 + STEP_N;
    w_k0_adv  = r_k0 + STEP_K;
    w_last_m  = (w_m0_adv >= r_m);
    w_last_n  = (w_n0_adv >= r_n);
    w_last_k  = (w_k0_adv >= r_k);
    w_a_mstep = ADDR_WIDTH'(r_k) << LOG_AN;
    w_w_kstep = ADDR_WIDTH'(r_n) << LOG_DEPTH;
    w_o_mstep = ADDR_WIDTH'(r_n) << LOG_AN;
    w_a_row_nx = r_a_row + w_a_mstep;
    w_a_cur_nx = r_a_cur + ASTEP_K;
    w_w_col_nx = r_w_col + ASTEP_AM;
    w_m0_nx   = r_m0;
    w_n0_nx   = r_n0;
    w_k0_nx   = r_k0;
    case (r_state)
      ST_IDLE: begin
        w_m0_nx = CW'(0);
        w_n0_nx = CW'(0);
        w_k0_nx = CW'(0);
      end
      ST_ISSUE_C: begin
        if (!w_last_k) begin
          w_k0_nx = w_k0_adv;
        end else begin
          w_k0_nx = r_k0;
        end
      end
      ST_ISSUE_D: begin
        w_k0_nx = CW'(0);
        if (!w_last_n) begin
          w_n0_nx = w_n0_adv;
        end else begin
          w_n0_nx = CW'(0);
          w_m0_nx = w_m0_adv;
        end
      end
      default: begin
        w_k0_nx = r_k0;
      end
    endcase
  end

  tile_extent_calc #(.DW(CW), .TILE(ARRAY_N)) u_rows_ext (
    .i_total(w_m_tot), .i_offset(w_m0_nx), .o_extent(w_rows_ext)
  );

  tile_extent_calc #(.DW(CW), .TILE(ARRAY_M)) u_cols_ext (
    .i_total(w_n_tot), .i_offset(w_n0_nx), .o_extent(w_cols_ext)
  );

  tile_extent_calc #(.DW(CW), .TILE(DEPTH)) u_depth_ext (
    .i_total(w_k_tot), .i_offset(w_k0_nx), .o_extent(w_depth_ext)
  );

  // Scheduler FSM: loads the next command's fields into the output registers on each handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_m             <= CW'(0);
      r_k             <= CW'(0);
      r_n             <= CW'(0);
      r_m0            <= CW'(0);
      r_n0            <= CW'(0);
      r_k0            <= CW'(0);
      r_w_base        <= ADDR_WIDTH'(0);
      r_a_row         <= ADDR_WIDTH'(0);
      r_a_cur         <= ADDR_WIDTH'(0);
      r_w_col         <= ADDR_WIDTH'(0);
      r_w_cur         <= ADDR_WIDTH'(0);
      r_o_row         <= ADDR_WIDTH'(0);
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_cmd_valid     <= 1'b0;
      r_cmd_op        <= OP_LOAD_A;
      r_cmd_addr      <= ADDR_WIDTH'(0);
      r_cmd_rows      <= ROWS_W'(0);
      r_cmd_cols      <= COLS_W'(0);
      r_cmd_depth     <= DEPTH_W'(0);
      r_cmd_acc_clear <= 1'b0;
    end else begin
      if (w_fire) begin
        r_m0        <= w_m0_nx;
        r_n0        <= w_n0_nx;
        r_k0        <= w_k0_nx;
        r_cmd_rows  <= w_rows_ext;
        r_cmd_cols  <= w_cols_ext;
        r_cmd_depth <= w_depth_ext;
      end
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (start) begin
            r_m      <= CW'(dim_m);
            r_k      <= CW'(dim_k);
            r_n      <= CW'(dim_n);
            r_w_base <= w_base;
            r_busy   <= 1'b1;
            if ((dim_m == DIM_WIDTH'(0)) || (dim_k == DIM_WIDTH'(0)) || (dim_n == DIM_WIDTH'(0))) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state         <= ST_ISSUE_A;
              r_m0            <= CW'(0);
              r_n0            <= CW'(0);
              r_k0            <= CW'(0);
              r_a_row         <= a_base;
              r_a_cur         <= a_base;
              r_w_col         <= w_base;
              r_w_cur         <= w_base;
              r_o_row         <= o_base;
              r_cmd_valid     <= 1'b1;
              r_cmd_op        <= OP_LOAD_A;
              r_cmd_addr      <= a_base;
              r_cmd_rows      <= w_rows_ext;
              r_cmd_cols      <= w_cols_ext;
              r_cmd_depth     <= w_depth_ext;
              r_cmd_acc_clear <= 1'b0;
            end
          end
        end
        ST_ISSUE_A: begin
          if (w_fire) begin
            r_state    <= ST_ISSUE_W;
            r_cmd_op   <= OP_LOAD_W;
            r_cmd_addr <= r_w_cur;
          end
        end
        ST_ISSUE_W: begin
          if (w_fire) begin
            r_state         <= ST_ISSUE_C;
            r_cmd_op        <= OP_COMPUTE;
            r_cmd_addr      <= ADDR_WIDTH'(0);
            r_cmd_acc_clear <= (r_k0 == CW'(0));
          end
        end
        ST_ISSUE_C: begin
          if (w_fire) begin
            r_cmd_acc_clear <= 1'b0;
            if (!w_last_k) begin
              r_state    <= ST_ISSUE_A;
              r_cmd_op   <= OP_LOAD_A;
              r_cmd_addr <= w_a_cur_nx;
              r_a_cur    <= w_a_cur_nx;
              r_w_cur    <= r_w_cur + w_w_kstep;
            end else begin
              r_state    <= ST_ISSUE_D;
              r_cmd_op   <= OP_DRAIN;
              r_cmd_addr <= r_o_row + ADDR_WIDTH'(r_n0);
            end
          end
        end
        ST_ISSUE_D: begin
          if (w_fire) begin
            if (w_last_n && w_last_m) begin
              r_state     <= ST_FINISH;
              r_cmd_valid <= 1'b0;
              r_done      <= 1'b1;
            end else if (w_last_n) begin
              // Next row of output tiles: step A and C rows, restart W at column 0.
              r_state    <= ST_ISSUE_A;
              r_cmd_op   <= OP_LOAD_A;
              r_cmd_addr <= w_a_row_nx;
              r_a_row    <= w_a_row_nx;
              r_a_cur    <= w_a_row_nx;
              r_w_col    <= r_w_base;
              r_w_cur    <= r_w_base;
              r_o_row    <= r_o_row + w_o_mstep;
            end else begin
              // Next tile in the same row: rewind A to the row start, step W columns.
              r_state    <= ST_ISSUE_A;
              r_cmd_op   <= OP_LOAD_A;
              r_cmd_addr <= r_a_row;
              r_a_cur    <= r_a_row;
              r_w_col    <= w_w_col_nx;
              r_w_cur    <= w_w_col_nx;
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_err       <= 1'b0;
        end
      endcase
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign err               = r_err;
  assign cmd.cmd_valid     = r_cmd_valid;
  assign cmd.cmd_op        = r_cmd_op;
  assign cmd.cmd_addr      = r_cmd_addr;
  assign cmd.cmd_rows      = r_cmd_rows;
  assign cmd.cmd_cols      = r_cmd_cols;
  assign cmd.cmd_depth     = r_cmd_depth;
  assign cmd.cmd_acc_clear = r_cmd_acc_clear;

endmodule
